// File: rtl/ram_512x8.sv
// 512x8 byte-addressed RAM with a mov/moc handshake and MIPS-style access sizes.
// Big-endian: the byte at the request address is the most significant one, and addresses wrap mod 512.
module ram_512x8 (
    input  logic        clk,
    input  logic        reset,
    input  logic        mov,
    input  logic        rw,
    input  logic [8:0]  address,
    input  logic [31:0] data_in,
    input  logic [5:0]  opcode,
    output logic [31:0] data_out,
    output logic        moc,
    output logic        dmoc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Decodes the opcode into an access size; every unlisted opcode is treated as a word access.
    function automatic logic [1:0] size_of(input logic [5:0] op);
        case (op)
            6'b100000, 6'b100100, 6'b101000: size_of = SZ_BYTE;
            6'b100001, 6'b100101, 6'b101001: size_of = SZ_HALF;
            default:                         size_of = SZ_WORD;
        endcase
    endfunction

    logic [7:0]  Mem [0:511];

    state_t      state_r;
    state_t      state_nxt_s;
    logic        rw_r;
    logic [8:0]  addr_r;
    logic [5:0]  op_r;
    logic [31:0] din_r;
    logic [1:0]  size_s;
    logic [8:0]  a1_s;
    logic [8:0]  a2_s;
    logic [8:0]  a3_s;
    logic [31:0] rdata_s;

    assign size_s = size_of(op_r);
    assign a1_s   = addr_r + 9'd1;
    assign a2_s   = addr_r + 9'd2;
    assign a3_s   = addr_r + 9'd3;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a request dropped during BUSY goes straight back to IDLE
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (mov) state_nxt_s = BUSY;
                else     state_nxt_s = IDLE;
            end
            BUSY: begin
                if (mov) state_nxt_s = DONE;
                else     state_nxt_s = IDLE;
            end
            DONE: begin
                if (mov) state_nxt_s = DONE;
                else     state_nxt_s = IDLE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Request capture: only sampled when a request is accepted in IDLE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rw_r   <= 1'b0;
            addr_r <= 9'd0;
            op_r   <= 6'd0;
            din_r  <= 32'd0;
        end else if (state_r == IDLE && mov) begin
            rw_r   <= rw;
            addr_r <= address;
            op_r   <= opcode;
            din_r  <= data_in;
        end else begin
            rw_r   <= rw_r;
            addr_r <= addr_r;
            op_r   <= op_r;
            din_r  <= din_r;
        end
    end

    // Read data alignment and sign/zero extension
    always_comb begin
        rdata_s = 32'd0;
        case (size_s)
            SZ_BYTE: begin
                if (op_r == 6'b100000) rdata_s = {{24{Mem[addr_r][7]}}, Mem[addr_r]};
                else                   rdata_s = {24'd0, Mem[addr_r]};
            end
            SZ_HALF: begin
                if (op_r == 6'b100001) rdata_s = {{16{Mem[addr_r][7]}}, Mem[addr_r], Mem[a1_s]};
                else                   rdata_s = {16'd0, Mem[addr_r], Mem[a1_s]};
            end
            default: rdata_s = {Mem[addr_r], Mem[a1_s], Mem[a2_s], Mem[a3_s]};
        endcase
    end

    // Storage write; reset holds the FSM in IDLE so an aborted write never lands
    always_ff @(posedge clk) begin
        if (state_r == BUSY && !rw_r) begin
            case (size_s)
                SZ_BYTE: Mem[addr_r] <= din_r[7:0];
                SZ_HALF: begin
                    Mem[addr_r] <= din_r[15:8];
                    Mem[a1_s]   <= din_r[7:0];
                end
                default: begin
                    Mem[addr_r] <= din_r[31:24];
                    Mem[a1_s]   <= din_r[23:16];
                    Mem[a2_s]   <= din_r[15:8];
                    Mem[a3_s]   <= din_r[7:0];
                end
            endcase
        end
    end

    // Handshake outputs and read data; dmoc can only fire from BUSY, which lasts one cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            moc      <= 1'b0;
            dmoc     <= 1'b0;
            data_out <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    moc  <= 1'b0;
                    dmoc <= 1'b0;
                end
                BUSY: begin
                    moc  <= mov;
                    dmoc <= 1'b1;
                    if (rw_r) data_out <= rdata_s;
                    else      data_out <= data_out;
                end
                DONE: begin
                    moc  <= mov;
                    dmoc <= 1'b0;
                end
                default: begin
                    moc  <= 1'b0;
                    dmoc <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_512x8.sv
// Directed bench for ram_512x8: handshake timing, access sizes, extension, wrap and reset abort.
module tb_ram_512x8;

    logic        clk;
    logic        reset;
    logic        mov;
    logic        rw;
    logic [8:0]  address;
    logic [31:0] data_in;
    logic [5:0]  opcode;
    logic [31:0] data_out;
    logic        moc;
    logic        dmoc;

    int          total;
    int          bad;
    logic [31:0] exp_dout;

    ram_512x8 dut (
        .clk      (clk),
        .reset    (reset),
        .mov      (mov),
        .rw       (rw),
        .address  (address),
        .data_in  (data_in),
        .opcode   (opcode),
        .data_out (data_out),
        .moc      (moc),
        .dmoc     (dmoc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete request with a single-cycle mov release after moc
    task automatic op(input string tag, input logic r, input logic [8:0] a,
                      input logic [5:0] opc, input logic [31:0] d, input logic [31:0] rexp);
        @(negedge clk);
        mov = 1'b1; rw = r; address = a; opcode = opc; data_in = d;
        @(posedge clk); #1;
        chk({tag, "_moc_e1"}, {31'd0, moc}, 32'd0);
        chk({tag, "_dmoc_e1"}, {31'd0, dmoc}, 32'd0);
        @(posedge clk); #1;
        if (r) exp_dout = rexp;
        else   exp_dout = exp_dout;
        chk({tag, "_moc_e2"}, {31'd0, moc}, 32'd1);
        chk({tag, "_dmoc_e2"}, {31'd0, dmoc}, 32'd1);
        chk({tag, "_dout"}, data_out, exp_dout);
        @(negedge clk);
        mov = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_moc_e3"}, {31'd0, moc}, 32'd0);
        chk({tag, "_dmoc_e3"}, {31'd0, dmoc}, 32'd0);
    endtask

    initial begin
        total = 0; bad = 0; exp_dout = 32'd0;
        reset = 1'b0; mov = 1'b0; rw = 1'b0; address = 9'd0; data_in = 32'd0; opcode = 6'd0;
        #2;
        chk("rst_moc", {31'd0, moc}, 32'd0);
        chk("rst_dmoc", {31'd0, dmoc}, 32'd0);
        chk("rst_dout", data_out, 32'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;

        // Preload through the port
        op("sw0",  1'b0, 9'd0,  6'b101011, 32'h8C010004, 32'd0);
        op("sb5",  1'b0, 9'd5,  6'b101000, 32'h000000F0, 32'd0);
        op("sb12", 1'b0, 9'd12, 6'b101000, 32'h0000005A, 32'd0);
        op("sw20", 1'b0, 9'd20, 6'b101011, 32'hDEADBEEF, 32'd0);
        chk("mem0", {24'd0, dut.Mem[0]}, 32'h8C);
        chk("mem3", {24'd0, dut.Mem[3]}, 32'h04);

        // lw addr 0 with mov held three extra cycles after moc
        @(negedge clk);
        mov = 1'b1; rw = 1'b1; address = 9'd0; opcode = 6'b100011; data_in = 32'd0;
        @(posedge clk); #1;
        chk("lw0_moc_e1", {31'd0, moc}, 32'd0);
        chk("lw0_dmoc_e1", {31'd0, dmoc}, 32'd0);
        @(posedge clk); #1;
        chk("lw0_moc_e2", {31'd0, moc}, 32'd1);
        chk("lw0_dmoc_e2", {31'd0, dmoc}, 32'd1);
        chk("lw0_dout", data_out, 32'h8C010004);
        exp_dout = 32'h8C010004;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("hold_moc", {31'd0, moc}, 32'd1);
            chk("hold_dmoc", {31'd0, dmoc}, 32'd0);
            chk("hold_dout", data_out, 32'h8C010004);
        end
        @(negedge clk);
        mov = 1'b0;
        @(posedge clk); #1;
        chk("hold_release_moc", {31'd0, moc}, 32'd0);
        chk("hold_release_dmoc", {31'd0, dmoc}, 32'd0);

        // Byte reads with sign and zero extension
        op("lb5",  1'b1, 9'd5, 6'b100000, 32'd0, 32'hFFFFFFF0);
        op("lbu5", 1'b1, 9'd5, 6'b100100, 32'd0, 32'h000000F0);

        // Halfword store then loads
        op("sh10", 1'b0, 9'd10, 6'b101001, 32'h0000ABCD, 32'd0);
        chk("mem10", {24'd0, dut.Mem[10]}, 32'hAB);
        chk("mem11", {24'd0, dut.Mem[11]}, 32'hCD);
        chk("mem12", {24'd0, dut.Mem[12]}, 32'h5A);
        op("lh10",  1'b1, 9'd10, 6'b100001, 32'd0, 32'hFFFFABCD);
        op("lhu10", 1'b1, 9'd10, 6'b100101, 32'd0, 32'h0000ABCD);

        // Word store wrapping past the top of memory
        op("sw510", 1'b0, 9'd510, 6'b101011, 32'h11223344, 32'd0);
        chk("mem510", {24'd0, dut.Mem[510]}, 32'h11);
        chk("mem511", {24'd0, dut.Mem[511]}, 32'h22);
        chk("mem0w",  {24'd0, dut.Mem[0]}, 32'h33);
        chk("mem1w",  {24'd0, dut.Mem[1]}, 32'h44);
        op("lw510", 1'b1, 9'd510, 6'b100011, 32'd0, 32'h11223344);
        op("lw0b",  1'b1, 9'd0,   6'b100011, 32'd0, 32'h33440004);

        // Inputs changed after acceptance are ignored
        @(negedge clk);
        mov = 1'b1; rw = 1'b1; address = 9'd5; opcode = 6'b100100;
        @(posedge clk);
        @(negedge clk);
        rw = 1'b0; address = 9'd0; opcode = 6'b101011; data_in = 32'h99999999;
        @(posedge clk); #1;
        chk("latch_dout", data_out, 32'h000000F0);
        chk("latch_moc", {31'd0, moc}, 32'd1);
        exp_dout = 32'h000000F0;
        @(negedge clk);
        mov = 1'b0;
        @(posedge clk); #1;
        chk("latch_mem0", {24'd0, dut.Mem[0]}, 32'h33);

        // mov dropped during BUSY: access completes, moc never rises
        @(negedge clk);
        mov = 1'b1; rw = 1'b1; address = 9'd10; opcode = 6'b100000;
        @(posedge clk);
        @(negedge clk);
        mov = 1'b0;
        @(posedge clk); #1;
        chk("drop_dmoc", {31'd0, dmoc}, 32'd1);
        chk("drop_moc", {31'd0, moc}, 32'd0);
        chk("drop_dout", data_out, 32'hFFFFFFAB);
        exp_dout = 32'hFFFFFFAB;
        @(posedge clk); #1;
        chk("drop_dmoc2", {31'd0, dmoc}, 32'd0);
        chk("drop_moc2", {31'd0, moc}, 32'd0);
        op("after_drop", 1'b1, 9'd12, 6'b100100, 32'd0, 32'h0000005A);

        // Reset while a word store is in BUSY
        @(negedge clk);
        mov = 1'b1; rw = 1'b0; address = 9'd20; opcode = 6'b101011; data_in = 32'h01020304;
        @(posedge clk);
        #2;
        reset = 1'b0; mov = 1'b0;
        #1;
        chk("abort_moc", {31'd0, moc}, 32'd0);
        chk("abort_dmoc", {31'd0, dmoc}, 32'd0);
        chk("abort_dout", data_out, 32'd0);
        exp_dout = 32'd0;
        @(posedge clk); #1;
        chk("abort_mem20", {24'd0, dut.Mem[20]}, 32'hDE);
        chk("abort_mem21", {24'd0, dut.Mem[21]}, 32'hAD);
        chk("abort_mem22", {24'd0, dut.Mem[22]}, 32'hBE);
        chk("abort_mem23", {24'd0, dut.Mem[23]}, 32'hEF);
        chk("abort_mem10", {24'd0, dut.Mem[10]}, 32'hAB);
        chk("abort_mem5",  {24'd0, dut.Mem[5]}, 32'hF0);
        @(negedge clk);
        reset = 1'b1;
        op("post_rst", 1'b1, 9'd21, 6'b100100, 32'd0, 32'h000000AD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_512x8.md
RAM_512X8 -- requirements
Module: ram_512x8

Interface
REQ-001 The block SHALL have exactly one clock and its reset SHALL be asynchronous and active-low; ports `clk` and `reset` follow the codebase names.
REQ-002 clk  input  1  rising-edge clock for all sequential logic.
REQ-003 reset  input  1  asynchronous, active-low; clears control state and outputs.
REQ-004 mov  input  1  memory operation valid (request), held high by master until moc seen.
REQ-005 rw  input  1  1 = read, 0 = write; latched with the request.
REQ-006 address  input  9  byte address of first (most significant) byte.
REQ-007 data_in  input  32  write data, right-justified (byte in [7:0], half in [15:0]).
REQ-008 opcode  input  6  MIPS opcode selecting access size/extension.
REQ-009 data_out  output  32  read data, registered.
REQ-010 moc  output  1  memory operation complete, level, handshake acknowledge.
REQ-011 dmoc  output  1  done pulse, exactly one clk cycle per completed operation.
REQ-012 Storage SHALL be an array `Mem[0:511]` of 8-bit bytes, hierarchically writable by a bench for preload.

Function
REQ-013 Size decode: 100000/100100/101000 = byte; 100001/100101/101001 = halfword; any other opcode = word.
REQ-014 Byte order SHALL be big-endian: Mem[a] is most significant byte; byte k accessed at (a+k) mod 512 (address wrap, no fault, no alignment check).
REQ-015 Reads: lb (100000) sign-extends, lh (100001) sign-extends, lbu (100100)/lhu (100101) zero-extend, word returns {Mem[a],Mem[a+1],Mem[a+2],Mem[a+3]}.
REQ-016 Writes: byte writes data_in[7:0] to Mem[a]; half writes [15:8],[7:0] to a,a+1; word writes [31:24]..[7:0] to a..a+3; other bytes untouched.
REQ-017 FSM states IDLE, BUSY, DONE.
REQ-018 IDLE: on rising edge with mov=1, latch rw, address, opcode, data_in; go BUSY.
REQ-019 BUSY: on next rising edge perform the access (write Mem or load data_out), pulse dmoc=1 for that cycle, set moc=1 if mov=1, go DONE.
REQ-020 Request-to-moc latency SHALL be exactly 2 rising edges after mov first sampled high.
REQ-021 DONE: moc stays 1 while mov=1; when mov sampled 0, moc->0 and go IDLE; a new request needs at least one IDLE edge.
REQ-022 Inputs changing during BUSY/DONE SHALL be ignored; the latched values are used.
REQ-023 mov dropped during BUSY: access still completes, dmoc pulses, moc stays 0, return to IDLE.
REQ-024 data_out SHALL change only on a completed read; writes leave it unchanged.
REQ-025 dmoc SHALL never be high two consecutive cycles.

Reset
REQ-026 reset=0 SHALL immediately force state IDLE, moc=0, dmoc=0, data_out=0.
REQ-027 Mem contents SHALL NOT be cleared by reset.
REQ-028 Reset during BUSY SHALL abort the operation; no Mem byte is modified.
REQ-029 After reset release, the first request is accepted on the first rising edge with mov=1.

Verification
REQ-030 Preload Mem[0..3]=8C,01,00,04; read opcode 100011 addr 0 -> data_out=8C010004, moc high 2 edges after mov, dmoc one-cycle pulse.
REQ-031 Mem[5]=F0; lb addr 5 -> FFFFFFF0; lbu addr 5 -> 000000F0.
REQ-032 sh (101001) addr 10 data_in=0000ABCD -> Mem[10]=AB, Mem[11]=CD, Mem[12] unchanged; lh addr 10 -> FFFFABCD.
REQ-033 sw (101011) addr 510 data_in=11223344 -> Mem[510]=11, Mem[511]=22, Mem[0]=33, Mem[1]=44; lw addr 510 returns 11223344.
REQ-034 Reset asserted in BUSY of sw addr 20 -> Mem[20..23] unchanged, moc=dmoc=0, data_out=0, preloaded bytes elsewhere intact.
REQ-035 Hold mov high 3 extra cycles after moc -> moc stays 1, dmoc pulses once, no second access; mov low -> moc 0 next edge.
